// File: rtl/seven_segment_pkg.sv
// Shared glyph table and helpers for the 7-segment scan driver.
// Glyph patterns are lit-high, bit6=a .. bit0=g.
package seven_segment_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Entry i is the glyph for hex digit i (listed F down to 0).
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,
        7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33,
        7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to lit-high 7-segment glyph.
// Pin polarity is applied by the parent.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    assign o_glyph = hex_to_glyph(i_nibble);

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with dead-time and
// frame-synchronous updates. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_segment_scan_driver
    import seven_segment_pkg::*;
#(
    parameter int DIGITS            = 4,
    parameter int CLK_DIV           = 16384,
    parameter int DEAD_CYCLES       = 512,
    parameter bit SEG_ACTIVE_LOW    = 1'b1,
    parameter bit ANODE_ACTIVE_HIGH = 1'b1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic                  ready,
    output logic [6:0]            segment,
    output logic                  segment_dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_strobe
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_PRELAST = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] DEAD_END     = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] DIGIT_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [DIGITS-1:0] ANODE_OFF =
        ANODE_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]    r_slot_cnt;
    logic [IDX_W-1:0]    r_digit_idx;

    logic [4*DIGITS-1:0] r_shadow_value;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [DIGITS-1:0]   r_shadow_blank;
    logic [4*DIGITS-1:0] r_disp_value;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [DIGITS-1:0]   r_disp_blank;
    logic                r_pending;

    logic [DIGITS-1:0]   r_anode;
    logic [6:0]          r_segment;
    logic                r_segment_dp;
    logic                r_frame_strobe;

    logic                w_frame_end;
    logic                w_pre_frame_end;
    logic                w_accept;
    logic                w_in_dead;
    logic                w_lit;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic [6:0]          w_seg_lit;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_dark;

    assign w_frame_end     = (r_digit_idx == DIGIT_LAST) &&
                             (r_slot_cnt == SLOT_LAST);
    assign w_pre_frame_end = (r_digit_idx == DIGIT_LAST) &&
                             (r_slot_cnt == SLOT_PRELAST);
    assign w_accept        = load && !r_pending;
    assign w_in_dead       = (DEAD_CYCLES != 0) && (r_slot_cnt < DEAD_END);
    assign w_nibble        = r_disp_value[4*int'(r_digit_idx) +: 4];
    assign w_onehot        = DIGITS'(1) << r_digit_idx;

    seven_segment_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

    // Leading-zero suppression mask, computed from the display registers.
    always_comb begin
        w_dark = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic w_seen;
            w_seen = 1'b0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                w_seen    = w_seen || (r_disp_value[4*i +: 4] != 4'h0);
                w_dark[i] = !w_seen && !r_disp_dp[i];
            end
        end
`endif
    end

    assign w_lit     = !w_in_dead &&
                       !r_disp_blank[r_digit_idx] &&
                       !w_dark[r_digit_idx];
    assign w_seg_lit = w_lit ? w_glyph : 7'h00;

    // Prescaler and digit scanner.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + 1'b1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
        end
    end

    // Load handshake into shadow, tear-free transfer at frame end.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '0;
            r_disp_value   <= '0;
            r_disp_dp      <= '0;
            r_disp_blank   <= '0;
            r_pending      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow_value <= value;
                r_shadow_dp    <= dp;
                r_shadow_blank <= blank;
            end
            if (w_frame_end && r_pending) begin
                r_disp_value <= r_shadow_value;
                r_disp_dp    <= r_shadow_dp;
                r_disp_blank <= r_shadow_blank;
            end
            r_pending <= w_accept || (r_pending && !w_frame_end);
        end
    end

    // Registered pins; strobe is pre-computed so it marks the frame-end cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_anode        <= ANODE_OFF;
            r_segment      <= SEG_OFF;
            r_segment_dp   <= SEG_ACTIVE_LOW;
            r_frame_strobe <= 1'b0;
        end else begin
            r_anode        <= (w_lit ? w_onehot : '0) ^
                              {DIGITS{!ANODE_ACTIVE_HIGH}};
            r_segment      <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
            r_segment_dp   <= (w_lit && r_disp_dp[r_digit_idx]) ^ SEG_ACTIVE_LOW;
            r_frame_strobe <= w_pre_frame_end;
        end
    end

    assign ready        = !r_pending;
    assign anode        = r_anode;
    assign segment      = r_segment;
    assign segment_dp   = r_segment_dp;
    assign frame_strobe = r_frame_strobe;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Randomised self-checking bench for seven_segment_scan_driver
// against a frame-level behavioural model.
module tb_seven_segment_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;
    logic        ready;
    logic [6:0]  segment;
    logic        segment_dp;
    logic [3:0]  anode;
    logic        frame_strobe;

    always #5 CLK = ~CLK;

    seven_segment_scan_driver #(
        .DIGITS            (DIGITS),
        .CLK_DIV           (CLK_DIV),
        .DEAD_CYCLES       (DEAD),
        .SEG_ACTIVE_LOW    (1'b1),
        .ANODE_ACTIVE_HIGH (1'b1)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .value        (value),
        .dp           (dp),
        .blank        (blank),
        .load         (load),
        .ready        (ready),
        .segment      (segment),
        .segment_dp   (segment_dp),
        .anode        (anode),
        .frame_strobe (frame_strobe)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] GLY [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // model state
    int       n;
    bit [3:0] mv [DIGITS];
    bit       mdp[DIGITS];
    bit       mbl[DIGITS];
    bit [3:0] sv [DIGITS];
    bit       sdp[DIGITS];
    bit       sbl[DIGITS];
    bit       pending;

    logic [3:0] exp_anode;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ready;
    logic       exp_strobe;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit shown(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0 || mdp[d]) return 1'b1;
        for (int j = d; j < DIGITS; j++)
            if (mv[j] != 4'h0) return 1'b1;
        return 1'b0;
`else
        return (d >= 0);
`endif
    endfunction

    task automatic model_reset();
        n = 0;
        pending = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            mv[i] = '0; mdp[i] = 0; mbl[i] = 0;
            sv[i] = '0; sdp[i] = 0; sbl[i] = 0;
        end
    endtask

    // Drive inputs for the next edge, predict, then check at negedge.
    task automatic step(input bit rst, input bit ld, input logic [15:0] v,
                        input logic [3:0] d, input logic [3:0] b);
        int pos, dig, ph;
        bit lit;
        reset = rst; load = ld; value = v; dp = d; blank = b;
        if (rst) begin
            model_reset();
            exp_anode = 4'h0; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            pos = n % FRAME;
            dig = pos / CLK_DIV;
            ph  = pos % CLK_DIV;
            lit = (ph >= DEAD) && !mbl[dig] && shown(dig);
            exp_anode = lit ? 4'(1 << dig) : 4'h0;
            exp_seg   = lit ? ~GLY[mv[dig]] : 7'h7F;
            exp_dp    = !(lit && mdp[dig]);
            if (pos == FRAME - 1 && pending) begin
                for (int i = 0; i < DIGITS; i++) begin
                    mv[i] = sv[i]; mdp[i] = sdp[i]; mbl[i] = sbl[i];
                end
                pending = 1'b0;
            end else if (ld && !pending) begin
                for (int i = 0; i < DIGITS; i++) begin
                    sv[i] = v[4*i +: 4]; sdp[i] = d[i]; sbl[i] = b[i];
                end
                pending = 1'b1;
            end
            n++;
        end
        exp_strobe = !rst && (n % FRAME == FRAME - 1);
        exp_ready  = !pending;
        @(negedge CLK);
        chk("anode", anode, exp_anode);
        chk("segment", segment, exp_seg);
        chk("seg_dp", segment_dp, exp_dp);
        chk("ready", ready, exp_ready);
        chk("strobe", frame_strobe, exp_strobe);
        chk("onehot", $countones(anode) <= 1, 1);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            step(0, 0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic wait_ready(input string tag);
        int c = 0;
        while (!exp_ready && c < 2 * FRAME) begin idle(1); c++; end
        if (!exp_ready) chk(tag, 0, 1);
    endtask

    initial begin
        int c;
        reset = 1; load = 0; value = '0; dp = '0; blank = '0;
        model_reset();

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("rst_anode", anode, 4'h0);
        chk("rst_seg", segment, 7'h7F);
        chk("rst_dp", segment_dp, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_strobe", frame_strobe, 1'b0);

        idle(2);
        step(0, 1, 16'h1234, 4'h0, 4'h0);
        chk("busy_after_load", ready, 1'b0);
        idle(3 * FRAME);

        wait_ready("wait_abcd");
        step(0, 1, 16'hABCD, 4'h0, 4'h0);
        step(0, 1, 16'h0000, 4'h0, 4'h0);
        idle(3 * FRAME);

        c = 0;
        while (!exp_strobe && c < 2 * FRAME) begin idle(1); c++; end
        chk("found_strobe", frame_strobe, 1'b1);
        step(0, 1, 16'h9E60, 4'h0, 4'h0);
        idle(3 * FRAME);

        wait_ready("wait_blank");
        step(0, 1, 16'h4321, 4'b0001, 4'b0100);
        idle(3 * FRAME);

        wait_ready("wait_lzb");
        step(0, 1, 16'h0007, 4'h0, 4'h0);
        idle(3 * FRAME);

        wait_ready("wait_mid");
        step(0, 1, 16'h5678, 4'h0, 4'h0);
        c = 0;
        while ((n % FRAME) != 2 * CLK_DIV + 3 && c < 2 * FRAME) begin
            idle(1); c++;
        end
        chk("reached_digit2", anode, 4'b0100);
        chk("pending_mid", ready, 1'b0);
        step(1, 0, 0, 0, 0);
        chk("midrst_anode", anode, 4'h0);
        chk("midrst_ready", ready, 1'b1);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 400) == 0, ($urandom % 10) == 0,
                 16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
